toaplan2_cen_gen: RTL and testbench

Multi-channel fractional clock-enable generator for the Toaplan2 cores. It turns the single fast system clock into per-channel enable pulses at an average rate of f·n/m, each with a binary-divided chain of taps and half-period-offset companions. The n/m ratio of each channel can be reprogrammed at run time, and a new ratio takes effect without glitches at the next period boundary. It sits between the PLL clock and every chip model that needs a CEN: the GP9001, the YM2151 and the OKI.

---
 rtl/toaplan2_cen_gen.sv | 156 +++++++++++++++
 tb/tb_toaplan2_cen_gen.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/toaplan2_cen_gen.sv
// toaplan2_cen_gen: multi-channel fractional clock-enable generator.
// Each channel accumulates n per cycle and ticks whenever the sum reaches m,
// giving an average tick rate of f*n/m. A binary counter of ticks derives
// the divided taps; the companion CENB outputs sit half a period away.
// New n/m ratios are captured into shadow registers and swapped in on the
// next tick so a period is never cut short or stretched.
//
// Optional feature: define TOAPLAN2_CEN_PAUSE_EN to add the PAUSE input,
// which freezes phase and suppresses pulses while LOAD capture keeps working.
//
// LOAD is a single-cycle strobe with no back-pressure: it is sampled on
// every rising CLK edge, accepted or rejected in that same cycle, and the
// outcome is visible on PEND/ERR the following cycle.
module toaplan2_cen_gen #(
  parameter int CH  = 2,
  parameter int W   = 8,
  parameter int DIV = 4,
  parameter int N0  = 1,
  parameter int M0  = 7
) (
  input  logic              CLK,
  input  logic              RESET_n,
  input  logic [CH*W-1:0]   N,
  input  logic [CH*W-1:0]   M,
  input  logic [CH-1:0]     LOAD,
`ifdef TOAPLAN2_CEN_PAUSE_EN
  input  logic              PAUSE,
`endif
  output logic [CH*DIV-1:0] CEN,
  output logic [CH*DIV-1:0] CENB,
  output logic [CH-1:0]     PEND,
  output logic [CH-1:0]     ERR
);

  // Tap counter width; a single-tap build still keeps a 1-bit counter.
  localparam int CW = (DIV > 1) ? DIV - 1 : 1;

  // Global run enable: low only while paused.
  logic run;
`ifdef TOAPLAN2_CEN_PAUSE_EN
  assign run = ~PAUSE;
`else
  assign run = 1'b1;
`endif

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [W-1:0]   n_q, n_d, m_q, m_d;
    logic [W-1:0]   sn_q, sn_d, sm_q, sm_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           pend_q, pend_d;
    logic           err_q, err_d;
    logic [DIV-1:0] cen_q, cen_d, cenb_q, cenb_d;

    logic [W:0]     sum;
    logic [W:0]     half_m;
    logic [W-1:0]   rem;
    logic [W-1:0]   ld_n, ld_m;
    logic           tick_raw, tick, half, ld_ok, apply;

    assign ld_n     = N[c*W +: W];
    assign ld_m     = M[c*W +: W];
    assign sum      = {1'b0, acc_q} + {1'b0, n_q};
    assign half_m   = {2'b00, m_q[W-1:1]};
    // acc stays below m, so the post-tick remainder always fits in W bits.
    assign rem      = W'(sum - {1'b0, m_q});
    assign tick_raw = (sum >= {1'b0, m_q});
    assign tick     = run && tick_raw;
    assign half     = run && !tick_raw && ({1'b0, acc_q} < half_m) && (sum >= half_m);
    assign ld_ok    = (ld_m != '0) && (ld_n <= ld_m);
    // A ratio accepted in this very cycle must wait for a later tick.
    assign apply    = tick && pend_q && !(LOAD[c] && ld_ok);

    // Next-state: accumulator/tap counter advance, ratio apply, LOAD capture, pulse decode.
    always_comb begin
      n_d    = n_q;
      m_d    = m_q;
      sn_d   = sn_q;
      sm_d   = sm_q;
      acc_d  = acc_q;
      cnt_d  = cnt_q;
      pend_d = pend_q;
      err_d  = err_q;
      cen_d  = '0;
      cenb_d = '0;

      if (tick) begin
        acc_d = rem;
        cnt_d = cnt_q + CW'(1);
      end else if (run) begin
        acc_d = sum[W-1:0];
      end

      if (apply) begin
        n_d    = sn_q;
        m_d    = sm_q;
        pend_d = 1'b0;
        // Carry the residue over unless it would already exceed the new period.
        if (rem >= sm_q) begin
          acc_d = '0;
        end
      end

      if (LOAD[c]) begin
        if (ld_ok) begin
          sn_d   = ld_n;
          sm_d   = ld_m;
          pend_d = 1'b1;
          err_d  = 1'b0;
        end else begin
          err_d  = 1'b1;
        end
      end

      cen_d[0]  = tick;
      cenb_d[0] = half;
      for (int k = 1; k < DIV; k++) begin
        cen_d[k]  = tick && ((cnt_q & CW'((1 << k) - 1)) == '0);
        cenb_d[k] = tick && ((cnt_q & CW'((1 << k) - 1)) == CW'(1 << (k - 1)));
      end
    end

    // Channel state register with synchronous active-low reset.
    always_ff @(posedge CLK) begin
      if (!RESET_n) begin
        n_q    <= W'(N0);
        m_q    <= W'(M0);
        sn_q   <= W'(N0);
        sm_q   <= W'(M0);
        acc_q  <= '0;
        cnt_q  <= '0;
        pend_q <= 1'b0;
        err_q  <= 1'b0;
        cen_q  <= '0;
        cenb_q <= '0;
      end else begin
        n_q    <= n_d;
        m_q    <= m_d;
        sn_q   <= sn_d;
        sm_q   <= sm_d;
        acc_q  <= acc_d;
        cnt_q  <= cnt_d;
        pend_q <= pend_d;
        err_q  <= err_d;
        cen_q  <= cen_d;
        cenb_q <= cenb_d;
      end
    end

    assign CEN[c*DIV +: DIV]  = cen_q;
    assign CENB[c*DIV +: DIV] = cenb_q;
    assign PEND[c]            = pend_q;
    assign ERR[c]             = err_q;
  end

endmodule

// File: tb/tb_toaplan2_cen_gen.sv
// tb_toaplan2_cen_gen: directed bench for toaplan2_cen_gen (CH=2, W=8, DIV=4).
// Expected channel-0 pulse vectors and channel-1 tick cycles are queued by the
// stimulus; a negedge monitor pops and compares whenever a pulse appears.
module tb_toaplan2_cen_gen;
  localparam int CH  = 2;
  localparam int W   = 8;
  localparam int DIV = 4;
  localparam int EW  = 32 + 2 * DIV;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [CH*W-1:0]   n_in;
  logic [CH*W-1:0]   m_in;
  logic [CH-1:0]     load;
`ifdef TOAPLAN2_CEN_PAUSE_EN
  logic              pause;
`endif
  logic [CH*DIV-1:0] cen;
  logic [CH*DIV-1:0] cenb;
  logic [CH-1:0]     pend;
  logic [CH-1:0]     err;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int c1_ticks = 0;

  logic [EW-1:0] exp_q[$];
  logic [31:0]   exp1_q[$];
  logic [EW-1:0] mon_act, mon_exp;
  logic [31:0]   mon1_exp;

  toaplan2_cen_gen #(.CH(CH), .W(W), .DIV(DIV), .N0(1), .M0(7)) dut (
    .CLK     (clk),
    .RESET_n (rst_n),
    .N       (n_in),
    .M       (m_in),
    .LOAD    (load),
`ifdef TOAPLAN2_CEN_PAUSE_EN
    .PAUSE   (pause),
`endif
    .CEN     (cen),
    .CENB    (cenb),
    .PEND    (pend),
    .ERR     (err)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: cyc=%0d, required finish before time limit", cyc);
    $fatal(1, "watchdog");
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if ((cen[DIV-1:0] | cenb[DIV-1:0]) != '0) begin
      mon_act = {32'(cyc), cen[DIV-1:0], cenb[DIV-1:0]};
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL ch0_pulse: unexpected cyc=%0d cen=%b cenb=%b, required no pulse",
                 cyc, cen[DIV-1:0], cenb[DIV-1:0]);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          miscompares++;
          $display("FAIL ch0_pulse: got cyc=%0d cen=%b cenb=%b, required cyc=%0d cen=%b cenb=%b",
                   cyc, cen[DIV-1:0], cenb[DIV-1:0], mon_exp[EW-1 -: 32],
                   mon_exp[2*DIV-1 -: DIV], mon_exp[DIV-1:0]);
        end
      end
    end
    if (cen[DIV] === 1'b1) begin
      c1_ticks++;
      vectors++;
      if (exp1_q.size() == 0) begin
        miscompares++;
        $display("FAIL ch1_tick: unexpected tick at cyc=%0d", cyc);
      end else begin
        mon1_exp = exp1_q.pop_front();
        if (32'(cyc) !== mon1_exp) begin
          miscompares++;
          $display("FAIL ch1_tick: got cyc=%0d, required cyc=%0d", cyc, mon1_exp);
        end
      end
    end
  end

  // Driver / helper tasks
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h (cyc=%0d)", name, act, exp, cyc);
    end
  endtask

  task automatic goto(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  function automatic logic [2*DIV-1:0] tick_bits(input int cnt);
    logic [DIV-1:0] ce, cb;
    ce    = '0;
    cb    = '0;
    ce[0] = 1'b1;
    for (int k = 1; k < DIV; k++) begin
      if (cnt % (1 << k) == 0)              ce[k] = 1'b1;
      if (cnt % (1 << k) == (1 << (k - 1))) cb[k] = 1'b1;
    end
    return {ce, cb};
  endfunction

  task automatic push_tick(input int t, input int cnt);
    exp_q.push_back({32'(t), tick_bits(cnt)});
  endtask

  task automatic push_half(input int t);
    logic [DIV-1:0] z, h;
    z = '0;
    h = '0;
    h[0] = 1'b1;
    exp_q.push_back({32'(t), z, h});
  endtask

  // Channel 0 at 1/7 from a zero accumulator at cycle base.
  task automatic push_ch0_7(input int base, input int j0, input int j1, input int cnt0);
    for (int j = j0; j <= j1; j++) begin
      push_half(base + 7 * j - 4);
      push_tick(base + 7 * j, cnt0 + j - j0);
    end
  endtask

  task automatic push_ch1_7(input int base, input int j1);
    for (int j = 1; j <= j1; j++) exp1_q.push_back(32'(base + 7 * j));
  endtask

  // Reset for two cycles with a (lost) LOAD, verify reset state, then release.
  task automatic reset_phase(input int last, output int r);
    goto(last);
    rst_n = 1'b0;
    load  = '1;
    n_in  = {CH{8'd3}};
    m_in  = {CH{8'd4}};
    @(negedge clk);
    check("rst_cen", 32'(cen), 0);
    check("rst_cenb", 32'(cenb), 0);
    check("rst_pend", 32'(pend), 0);
    check("rst_err", 32'(err), 0);
    check("ch0_leftover", exp_q.size(), 0);
    check("ch1_leftover", exp1_q.size(), 0);
    @(negedge clk);
    check("rst_load_lost", 32'(pend), 0);
    load  = '0;
    rst_n = 1'b1;
    r     = cyc;
  endtask

  // Stimulus
  initial begin
    int r;
    int snap;
    rst_n = 1'b0;
    load  = '0;
    n_in  = '0;
    m_in  = '0;
`ifdef TOAPLAN2_CEN_PAUSE_EN
    pause = 1'b0;
`endif
    reset_phase(0, r);

    // Ch0 at 1/7 with all taps; ch1 reloaded to 2/7 for a 7000-cycle run.
    push_ch0_7(r, 1, 1001, 0);
    exp1_q.push_back(32'(r + 7));
    for (int i = 0; i < 1000; i++) begin
      exp1_q.push_back(32'(r + 11 + 7 * i));
      exp1_q.push_back(32'(r + 14 + 7 * i));
    end
    n_in[2*W-1:W] = 8'd2;
    m_in[2*W-1:W] = 8'd7;
    load = 2'b10;
    goto(r + 1); load = '0; check("pend_b_set", 32'(pend), 2);
    goto(r + 7); check("pend_b_apply", 32'(pend), 0);
    goto(r + 8); snap = c1_ticks;
    goto(r + 7008); check("ch1_count_7000", c1_ticks - snap, 2000);
    reset_phase(r + 7008, r);

    // Reprogram ch0 to 1/35 three cycles after a tick; ch1 stays at 1/7.
    push_ch0_7(r, 1, 2, 0);
    for (int i = 1; i <= 4; i++) begin
      push_half(r + 14 + 35 * i - 18);
      push_tick(r + 14 + 35 * i, 1 + i);
    end
    push_ch1_7(r, 22);
    goto(r + 9);  n_in[W-1:0] = 8'd1; m_in[W-1:0] = 8'd35; load = 2'b01;
    goto(r + 10); load = '0; check("pend_c_set", 32'(pend), 1);
    goto(r + 13); check("pend_c_hold", 32'(pend), 1);
    goto(r + 14); check("pend_c_apply", 32'(pend), 0);
    reset_phase(r + 154, r);

    // Rejected loads (m=0, n>m), then a valid load clears ERR.
    push_ch0_7(r, 1, 8, 0);
    push_ch1_7(r, 8);
    goto(r + 1);  n_in[W-1:0] = 8'd5; m_in[W-1:0] = 8'd0; load = 2'b01;
    goto(r + 2);  load = '0; check("err_m0", 32'(err), 1); check("pend_m0", 32'(pend), 0);
    goto(r + 3);  n_in[W-1:0] = 8'd9; m_in[W-1:0] = 8'd8; load = 2'b01;
    goto(r + 4);  load = '0; check("err_ngtm", 32'(err), 1); check("pend_ngtm", 32'(pend), 0);
    goto(r + 19); n_in[W-1:0] = 8'd1; m_in[W-1:0] = 8'd7; load = 2'b01;
    goto(r + 20); load = '0; check("err_clear", 32'(err), 0); check("pend_d_set", 32'(pend), 1);
    goto(r + 21); check("pend_d_apply", 32'(pend), 0);
    reset_phase(r + 56, r);

    // Back-to-back loads: last one (5/5, n==m) wins; tick every cycle, no CENB[0].
    push_ch0_7(r, 1, 1, 0);
    for (int i = 0; i <= 32; i++) push_tick(r + 8 + i, 1 + i);
    push_ch1_7(r, 5);
    n_in[W-1:0] = 8'd3; m_in[W-1:0] = 8'd3; load = 2'b01;
    goto(r + 1); n_in[W-1:0] = 8'd1; m_in[W-1:0] = 8'd35;
    goto(r + 2); n_in[W-1:0] = 8'd5; m_in[W-1:0] = 8'd5;
    goto(r + 3); load = '0; check("pend_f_set", 32'(pend), 1);
    goto(r + 7); check("pend_f_apply", 32'(pend), 0);
    reset_phase(r + 40, r);

    // 6/7 then 1/3: residue 4 at apply is >= 3, so the accumulator clears.
    push_half(r + 3); push_tick(r + 7, 0);
    push_half(r + 8); push_tick(r + 9, 1); push_tick(r + 10, 2);
    for (int i = 0; i <= 9; i++) begin
      push_half(r + 11 + 3 * i);
      push_tick(r + 13 + 3 * i, 3 + i);
    end
    push_ch1_7(r, 5);
    n_in[W-1:0] = 8'd6; m_in[W-1:0] = 8'd7; load = 2'b01;
    goto(r + 1);  load = '0; check("pend_g_set", 32'(pend), 1);
    goto(r + 7);  check("pend_g_apply", 32'(pend), 0);
    goto(r + 8);  n_in[W-1:0] = 8'd1; m_in[W-1:0] = 8'd3; load = 2'b01;
    goto(r + 9);  load = '0; check("pend_g_set2", 32'(pend), 1);
    goto(r + 10); check("pend_g_apply2", 32'(pend), 0);
    reset_phase(r + 40, r);

    // One-cycle reset mid-period with a pending ratio; it must be dropped.
    push_half(r + 3); push_tick(r + 7, 0); push_half(r + 10);
    push_ch0_7(r + 14, 1, 4, 0);
    exp1_q.push_back(32'(r + 7));
    push_ch1_7(r + 14, 4);
    goto(r + 8);  n_in[W-1:0] = 8'd1; m_in[W-1:0] = 8'd35; load = 2'b01;
    goto(r + 9);  load = '0; check("pend_e_set", 32'(pend), 1);
    goto(r + 13); rst_n = 1'b0;
    goto(r + 14);
    check("mid_rst_cen", 32'(cen), 0);
    check("mid_rst_cenb", 32'(cenb), 0);
    check("mid_rst_pend", 32'(pend), 0);
    check("mid_rst_err", 32'(err), 0);
    rst_n = 1'b1;
    reset_phase(r + 42, r);

`ifdef TOAPLAN2_CEN_PAUSE_EN
    // PAUSE for 100 cycles starting two cycles after a tick.
    push_half(r + 3); push_tick(r + 7, 0);
    push_ch0_7(r + 107, 1, 4, 1);
    exp1_q.push_back(32'(r + 7));
    push_ch1_7(r + 107, 4);
    goto(r + 9);   pause = 1'b1;
    goto(r + 109); pause = 1'b0;
    reset_phase(r + 135, r);
`endif

    reset_phase(cyc, r);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
